// File: rtl/uop_sequencer.sv
// Microcode sequencer: walks the uop ROM, decodes each uop's control field and
// streams its payload to the execute stage over a valid/ready handshake.
module uop_sequencer #(
  parameter  int UOP_BUF_SIZE  = 128,
  parameter  int UOP_BUF_WIDTH = 64,
  parameter  int STACK_DEPTH   = 4,
  localparam int AW            = $clog2(UOP_BUF_SIZE),
  localparam int PW            = UOP_BUF_WIDTH - 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [AW-1:0]            entry_addr,
  input  logic                     abort,
  output logic [AW-1:0]            uop_addr,
  input  logic [UOP_BUF_WIDTH-1:0] uop,
  input  logic [15:0]              cond_flags,
  output logic                     uop_valid,
  input  logic                     uop_ready,
  output logic [PW-1:0]            uop_payload,
  output logic                     busy,
  output logic                     done,
  output logic                     error
);

  localparam int SPW = $clog2(STACK_DEPTH + 1);
  localparam int SIW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, ERROR} state_t;

  localparam logic [3:0] CTL_JUMP   = 4'd1;
  localparam logic [3:0] CTL_BRANCH = 4'd2;
  localparam logic [3:0] CTL_CALL   = 4'd3;
  localparam logic [3:0] CTL_RET    = 4'd4;
  localparam logic [3:0] CTL_END    = 4'd5;

  state_t         state, state_nxt;
  logic [AW-1:0]  upc, upc_nxt;
  logic [SPW-1:0] sp, sp_nxt;
  logic           error_nxt, done_nxt, push;
  logic [AW-1:0]  stack [STACK_DEPTH];

  logic [3:0]    ctl;
  logic [7:0]    tgt_field;
  logic [AW-1:0] tgt;
  logic [3:0]    sel;
  logic [AW-1:0] upc_inc;
  logic          unused_tgt_bits;

  // Target field is 8 bits wide in the uop; only the low AW bits address the ROM.
  assign ctl             = uop[UOP_BUF_WIDTH-1 -: 4];
  assign tgt_field       = uop[PW+4 +: 8];
  assign tgt             = tgt_field[AW-1:0];
  assign sel             = uop[PW +: 4];
  assign unused_tgt_bits = ^tgt_field;
  assign upc_inc         = (upc == AW'(UOP_BUF_SIZE - 1)) ? '0 : upc + 1'b1;

  assign uop_addr    = upc;
  assign uop_payload = uop[PW-1:0];
  assign uop_valid   = (state == RUN);
  assign busy        = (state == RUN);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      upc   <= '0;
      sp    <= '0;
      done  <= 1'b0;
      error <= 1'b0;
    end else begin
      state <= state_nxt;
      upc   <= upc_nxt;
      sp    <= sp_nxt;
      done  <= done_nxt;
      error <= error_nxt;
    end
  end

  // Return-stack storage needs no reset: entries are only read below sp.
  always_ff @(posedge clk) begin
    if (push) stack[SIW'(sp)] <= upc_inc;
  end

  always_comb begin
    state_nxt = state;
    upc_nxt   = upc;
    sp_nxt    = sp;
    error_nxt = error;
    done_nxt  = 1'b0;
    push      = 1'b0;
    if (abort) begin
      state_nxt = IDLE;
      sp_nxt    = '0;
      error_nxt = 1'b0;
    end else begin
      unique case (state)
        IDLE, ERROR: begin
          if (start) begin
            state_nxt = RUN;
            upc_nxt   = entry_addr;
            sp_nxt    = '0;
            error_nxt = 1'b0;
          end
        end
        RUN: begin
          if (uop_ready) begin
            upc_nxt = upc_inc;
            case (ctl)
              CTL_JUMP:   upc_nxt = tgt;
              CTL_BRANCH: if (cond_flags[sel]) upc_nxt = tgt;
              CTL_CALL: begin
                if (sp == SPW'(STACK_DEPTH)) begin
                  upc_nxt   = upc;
                  state_nxt = ERROR;
                  error_nxt = 1'b1;
                end else begin
                  push    = 1'b1;
                  sp_nxt  = sp + 1'b1;
                  upc_nxt = tgt;
                end
              end
              CTL_RET: begin
                if (sp == '0) begin
                  upc_nxt   = upc;
                  state_nxt = ERROR;
                  error_nxt = 1'b1;
                end else begin
                  sp_nxt  = sp - 1'b1;
                  upc_nxt = stack[SIW'(sp - 1'b1)];
                end
              end
              CTL_END: begin
                upc_nxt   = upc;
                state_nxt = IDLE;
                sp_nxt    = '0;
                done_nxt  = 1'b1;
              end
              default: ;
            endcase
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uop_sequencer.sv
// Directed testbench for uop_sequencer: a behavioural ROM in the bench feeds
// the DUT, and each task checks addresses and status against hand-derived values.
module tb_uop_sequencer;

  localparam int AW = 7;
  localparam int PW = 48;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] entry_addr = '0;
  logic          abort = 1'b0;
  logic [AW-1:0] uop_addr;
  logic [63:0]   uop;
  logic [15:0]   cond_flags = '0;
  logic          uop_valid;
  logic          uop_ready = 1'b0;
  logic [PW-1:0] uop_payload;
  logic          busy, done, error;

  logic [63:0] rom [128];
  int compared = 0;
  int mismatched = 0;

  assign uop = rom[uop_addr];

  always #5 clk = ~clk;

  uop_sequencer #(.UOP_BUF_SIZE(128), .UOP_BUF_WIDTH(64), .STACK_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .start(start), .entry_addr(entry_addr), .abort(abort),
    .uop_addr(uop_addr), .uop(uop), .cond_flags(cond_flags), .uop_valid(uop_valid),
    .uop_ready(uop_ready), .uop_payload(uop_payload), .busy(busy), .done(done), .error(error)
  );

  function automatic logic [63:0] mk(input logic [3:0] c, input logic [7:0] t,
                                     input logic [3:0] s, input logic [47:0] p);
    return {c, t, s, p};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2;
    compared++; if (uop_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_valid got %b want 0", uop_valid); end
    compared++; if (busy !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
    compared++; if (done !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_done got %b want 0", done); end
    compared++; if (error !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_error got %b want 0", error); end
    compared++; if (uop_addr !== 7'd0) begin mismatched++; $display("[TB] FAIL reset_addr got %0d want 0", uop_addr); end
    tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic test_sequential();
    uop_ready = 1'b1;
    start = 1'b1; entry_addr = 7'd10;
    tick();
    start = 1'b0;
    for (int a = 10; a <= 13; a++) begin
      compared++; if (uop_addr !== 7'(a)) begin mismatched++; $display("[TB] FAIL seq_addr got %0d want %0d", uop_addr, a); end
      compared++; if (uop_valid !== 1'b1) begin mismatched++; $display("[TB] FAIL seq_valid got %b want 1", uop_valid); end
      compared++; if (done !== 1'b0) begin mismatched++; $display("[TB] FAIL seq_done_early got %b want 0", done); end
      tick();
    end
    compared++; if (done !== 1'b1) begin mismatched++; $display("[TB] FAIL seq_done got %b want 1", done); end
    compared++; if (busy !== 1'b0) begin mismatched++; $display("[TB] FAIL seq_busy got %b want 0", busy); end
    compared++; if (uop_addr !== 7'd13) begin mismatched++; $display("[TB] FAIL seq_end_addr got %0d want 13", uop_addr); end
    tick();
    compared++; if (done !== 1'b0) begin mismatched++; $display("[TB] FAIL seq_done_pulse got %b want 0", done); end
  endtask

  task automatic test_backpressure();
    uop_ready = 1'b1;
    start = 1'b1; entry_addr = 7'd10;
    tick();
    start = 1'b0;
    tick();
    uop_ready = 1'b0;
    start = 1'b1; entry_addr = 7'd99;
    for (int i = 0; i < 3; i++) begin
      compared++; if (uop_addr !== 7'd11) begin mismatched++; $display("[TB] FAIL bp_addr got %0d want 11", uop_addr); end
      compared++; if (uop_payload !== 48'hA0000000000B) begin mismatched++; $display("[TB] FAIL bp_payload got %h want a0000000000b", uop_payload); end
      tick();
    end
    start = 1'b0;
    uop_ready = 1'b1;
    compared++; if (uop_addr !== 7'd11) begin mismatched++; $display("[TB] FAIL bp_hold got %0d want 11", uop_addr); end
    tick();
    compared++; if (uop_addr !== 7'd12) begin mismatched++; $display("[TB] FAIL bp_advance got %0d want 12", uop_addr); end
    tick();
    tick();
    compared++; if (done !== 1'b1) begin mismatched++; $display("[TB] FAIL bp_done got %b want 1", done); end
    tick();
  endtask

  task automatic test_branch();
    uop_ready = 1'b1;
    cond_flags = 16'h0008;
    start = 1'b1; entry_addr = 7'd20;
    tick();
    start = 1'b0;
    compared++; if (uop_addr !== 7'd20) begin mismatched++; $display("[TB] FAIL br_entry got %0d want 20", uop_addr); end
    tick();
    cond_flags = 16'h0000;
    compared++; if (uop_addr !== 7'd40) begin mismatched++; $display("[TB] FAIL br_taken got %0d want 40", uop_addr); end
    tick();
    tick();
    start = 1'b1; entry_addr = 7'd20;
    tick();
    start = 1'b0;
    cond_flags = 16'hFFF7;
    tick();
    cond_flags = 16'h0000;
    compared++; if (uop_addr !== 7'd21) begin mismatched++; $display("[TB] FAIL br_not_taken got %0d want 21", uop_addr); end
    tick();
    tick();
  endtask

  task automatic test_call_ret();
    uop_ready = 1'b1;
    start = 1'b1; entry_addr = 7'd5;
    tick();
    start = 1'b0;
    compared++; if (uop_addr !== 7'd5) begin mismatched++; $display("[TB] FAIL call_entry got %0d want 5", uop_addr); end
    tick();
    compared++; if (uop_addr !== 7'd60) begin mismatched++; $display("[TB] FAIL call_target got %0d want 60", uop_addr); end
    tick();
    compared++; if (uop_addr !== 7'd6) begin mismatched++; $display("[TB] FAIL ret_addr got %0d want 6", uop_addr); end
    tick();
    compared++; if (done !== 1'b1) begin mismatched++; $display("[TB] FAIL call_done got %b want 1", done); end
    start = 1'b1; entry_addr = 7'd70;
    tick();
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      compared++; if (uop_addr !== 7'(70 + i)) begin mismatched++; $display("[TB] FAIL nest_addr got %0d want %0d", uop_addr, 70 + i); end
      compared++; if (error !== 1'b0) begin mismatched++; $display("[TB] FAIL nest_error_early got %b want 0", error); end
      tick();
    end
    compared++; if (error !== 1'b1) begin mismatched++; $display("[TB] FAIL overflow_error got %b want 1", error); end
    compared++; if (uop_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL overflow_valid got %b want 0", uop_valid); end
    tick();
    compared++; if (error !== 1'b1) begin mismatched++; $display("[TB] FAIL error_sticky got %b want 1", error); end
    start = 1'b1; entry_addr = 7'd10;
    tick();
    start = 1'b0;
    compared++; if (error !== 1'b0) begin mismatched++; $display("[TB] FAIL error_clear got %b want 0", error); end
    compared++; if (uop_addr !== 7'd10 || uop_valid !== 1'b1) begin mismatched++; $display("[TB] FAIL restart got addr %0d valid %b want 10/1", uop_addr, uop_valid); end
    repeat (4) tick();
    compared++; if (done !== 1'b1) begin mismatched++; $display("[TB] FAIL restart_done got %b want 1", done); end
    tick();
  endtask

  task automatic test_wrap();
    uop_ready = 1'b1;
    start = 1'b1; entry_addr = 7'd127;
    tick();
    start = 1'b0;
    compared++; if (uop_addr !== 7'd127) begin mismatched++; $display("[TB] FAIL wrap_entry got %0d want 127", uop_addr); end
    tick();
    compared++; if (uop_addr !== 7'd0) begin mismatched++; $display("[TB] FAIL wrap_addr got %0d want 0", uop_addr); end
    tick();
    compared++; if (error !== 1'b1) begin mismatched++; $display("[TB] FAIL underflow_error got %b want 1", error); end
    compared++; if (busy !== 1'b0) begin mismatched++; $display("[TB] FAIL underflow_busy got %b want 0", busy); end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    compared++; if (error !== 1'b0) begin mismatched++; $display("[TB] FAIL abort_clears_error got %b want 0", error); end
  endtask

  task automatic test_abort();
    uop_ready = 1'b1;
    start = 1'b1; entry_addr = 7'd30;
    tick();
    start = 1'b0;
    tick();
    compared++; if (uop_addr !== 7'd33) begin mismatched++; $display("[TB] FAIL abort_pre_addr got %0d want 33", uop_addr); end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    compared++; if (busy !== 1'b0 || uop_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL abort_idle got busy %b valid %b want 0/0", busy, uop_valid); end
    compared++; if (uop_addr !== 7'd33) begin mismatched++; $display("[TB] FAIL abort_no_retire got %0d want 33", uop_addr); end
    compared++; if (done !== 1'b0) begin mismatched++; $display("[TB] FAIL abort_done got %b want 0", done); end
    tick();
    compared++; if (done !== 1'b0) begin mismatched++; $display("[TB] FAIL abort_done_late got %b want 0", done); end
    start = 1'b1; entry_addr = 7'd0;
    tick();
    start = 1'b0;
    tick();
    compared++; if (error !== 1'b1) begin mismatched++; $display("[TB] FAIL abort_sp_cleared got error %b want 1", error); end
    start = 1'b1; entry_addr = 7'd10;
    tick();
    start = 1'b0;
    tick();
    reset = 1'b0;
    #1;
    compared++; if (uop_valid !== 1'b0 || busy !== 1'b0) begin mismatched++; $display("[TB] FAIL midrun_reset_state got valid %b busy %b want 0/0", uop_valid, busy); end
    compared++; if (uop_addr !== 7'd0) begin mismatched++; $display("[TB] FAIL midrun_reset_addr got %0d want 0", uop_addr); end
    compared++; if (error !== 1'b0 || done !== 1'b0) begin mismatched++; $display("[TB] FAIL midrun_reset_flags got error %b done %b want 0/0", error, done); end
    tick();
    reset = 1'b1;
    tick();
  endtask

  initial begin
    for (int i = 0; i < 128; i++) rom[i] = mk(4'd0, 8'd0, 4'd0, 48'hA00000000000 | 48'(i));
    rom[13]  = mk(4'd5, 8'd0, 4'd0, 48'hA0000000000D);
    rom[20]  = mk(4'd2, 8'd40, 4'd3, 48'hA00000000014);
    rom[21]  = mk(4'd5, 8'd0, 4'd0, 48'hA00000000015);
    rom[40]  = mk(4'd5, 8'd0, 4'd0, 48'hA00000000028);
    rom[5]   = mk(4'd3, 8'd60, 4'd0, 48'hA00000000005);
    rom[60]  = mk(4'd4, 8'd0, 4'd0, 48'hA0000000003C);
    rom[6]   = mk(4'd5, 8'd0, 4'd0, 48'hA00000000006);
    for (int i = 70; i < 75; i++) rom[i] = mk(4'd3, 8'(i + 1), 4'd0, 48'hA00000000000 | 48'(i));
    rom[0]   = mk(4'd4, 8'd0, 4'd0, 48'hA00000000000);
    rom[30]  = mk(4'd3, 8'd33, 4'd0, 48'hA0000000001E);
    rom[34]  = mk(4'd5, 8'd0, 4'd0, 48'hA00000000022);

    test_reset();
    test_sequential();
    test_backpressure();
    test_branch();
    test_call_ret();
    test_wrap();
    test_abort();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
